// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter / branch-resolution stage.
// The optional PC_CYCLE_CNT_EN macro (see pc_ctrl) does not affect this file.
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int PC_W_DEF      = 10;
  localparam int LUT_IDX_W_DEF = 4;
  localparam int LUT_DEPTH_DEF = 2 ** LUT_IDX_W_DEF;
  localparam int CNT_W         = 16;

  // Branch offsets as 16-bit two's complement. jump_lut narrows or
  // sign-extends each entry to the configured PC width.
  // Entries 0, 3 and 4 are fixed; the rest belong to the loaded program.
  localparam logic signed [15:0] JUMP_LUT [LUT_DEPTH_DEF] = '{
    16'sd0,    // 0: self-loop
    16'sd1,    // 1
    16'sd2,    // 2
    16'sd5,    // 3
    -16'sd3,   // 4
    -16'sd1,   // 5
    16'sd16,   // 6
    16'sd49,   // 7
    -16'sd16,  // 8
    16'sd100,  // 9
    -16'sd100, // 10
    16'sd8,    // 11
    -16'sd8,   // 12
    16'sd32,   // 13
    -16'sd32,  // 14
    16'sd511   // 15
  };

endpackage

// File: rtl/jump_lut.sv
// Constant jump-offset table: target_idx -> PC_W-bit two's-complement offset.
// Indices beyond the package table (only possible with a wider LUT_IDX_W)
// read as offset 0.
module jump_lut
  import pc_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int LUT_IDX_W = LUT_IDX_W_DEF
) (
  input  logic [LUT_IDX_W-1:0] target_idx,
  output logic [PC_W-1:0]      offset
);

  localparam int DEPTH = 2 ** LUT_IDX_W;

  logic [PC_W-1:0] table_w [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    if (i < LUT_DEPTH_DEF) begin : g_pkg
      // Signed size cast sign-extends or truncates to the PC width.
      assign table_w[i] = PC_W'(JUMP_LUT[i]);
    end else begin : g_zero
      assign table_w[i] = '0;
    end
  end

  assign offset = table_w[target_idx];

endmodule

// File: rtl/pc_ctrl.sv
// Program counter and branch resolution with the start/done handshake.
// Optional feature: define PC_CYCLE_CNT_EN to add a saturating 16-bit
// cycle_count output that counts RUN cycles (stalls included).
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int LUT_IDX_W = LUT_IDX_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 halt,
  input  logic                 jump_en,
  input  logic                 branch_en,
  input  logic                 flag,
  input  logic [LUT_IDX_W-1:0] target_idx,
  output logic [PC_W-1:0]      pc,
  output logic                 taken,
  output logic                 done
`ifdef PC_CYCLE_CNT_EN
  ,
  output logic [CNT_W-1:0]     cycle_count
`endif
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            taken_q, taken_d;
  logic            done_q, done_d;
  logic [PC_W-1:0] offset;
  logic            redirect;
  logic            start_acc;

  jump_lut #(
    .PC_W      (PC_W),
    .LUT_IDX_W (LUT_IDX_W)
  ) u_lut (
    .target_idx (target_idx),
    .offset     (offset)
  );

  // A jump, or a branch whose ALU flag is set, redirects; jump wins over flag.
  assign redirect  = jump_en | (branch_en & flag);
  // start only matters outside RUN.
  assign start_acc = start & (state_q != RUN);

  // Next-state / next-PC; stall beats halt beats redirect beats increment.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    taken_d = 1'b0;
    done_d  = done_q;
    unique case (state_q)
      IDLE: begin
        pc_d   = '0;
        done_d = 1'b0;
        if (start) state_d = RUN;
      end
      RUN: begin
        if (!stall) begin
          if (halt) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (redirect) begin
            pc_d    = pc_q + offset;
            taken_d = 1'b1;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      DONE: begin
        done_d = 1'b1;
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State, PC and handshake registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      taken_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
      done_q  <= done_d;
    end
  end

  assign pc    = pc_q;
  assign taken = taken_q;
  assign done  = done_q;

`ifdef PC_CYCLE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count every RUN cycle, saturating; cleared when start is accepted.
  always_comb begin
    cnt_d = cnt_q;
    if (start_acc) begin
      cnt_d = '0;
    end else if ((state_q == RUN) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cycle_count = cnt_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Table-driven bench for pc_ctrl: one long directed program walk, plus
// hand-written reset-mid-run and (when enabled) cycle counter sequences.
module tb_pc_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, stall, halt, jump_en, branch_en, flag;
  logic [3:0] target_idx;
  logic [9:0] pc;
  logic       taken, done;
`ifdef PC_CYCLE_CNT_EN
  logic [15:0] cycle_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stall      (stall),
    .halt       (halt),
    .jump_en    (jump_en),
    .branch_en  (branch_en),
    .flag       (flag),
    .target_idx (target_idx),
    .pc         (pc),
    .taken      (taken),
    .done       (done)
`ifdef PC_CYCLE_CNT_EN
    ,
    .cycle_count(cycle_count)
`endif
  );

  typedef struct {
    string      name;
    logic       st, sl, h, j, b, f;
    logic [3:0] idx;
    logic [9:0] pc;
    logic       tk, dn;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic st, sl, h, j, b, f,
                     input logic [3:0] idx, input logic [9:0] epc,
                     input logic etk, edn);
    vec_t v;
    v.name = n; v.st = st; v.sl = sl; v.h = h; v.j = j; v.b = b; v.f = f;
    v.idx = idx; v.pc = epc; v.tk = etk; v.dn = edn;
    vecs.push_back(v);
  endtask

  task automatic chk(input string n, input logic [15:0] act, exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, check just after it.
  task automatic step(input logic rst, st, sl, h, j, b, f, input logic [3:0] idx);
    reset = rst; start = st; stall = sl; halt = h;
    jump_en = j; branch_en = b; flag = f; target_idx = idx;
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string n, input logic [9:0] epc,
                      input logic etk, edn);
    chk({n, ".pc"},    16'(pc),    16'(epc));
    chk({n, ".taken"}, 16'(taken), 16'(etk));
    chk({n, ".done"},  16'(done),  16'(edn));
  endtask

  initial begin
    //   name           st sl h  j  b  f  idx   pc   tk dn
    add("start",        1, 0, 0, 0, 0, 0, 4'd0, 10'd0,  0, 0);
    for (int i = 1; i <= 7; i++)
      add($sformatf("seq%0d", i), 0, 0, 0, 0, 0, 0, 4'd0, 10'(i), 0, 0);
    add("br_taken",     0, 0, 0, 0, 1, 1, 4'd3, 10'd12, 1, 0);
    add("taken_pulse",  0, 0, 0, 0, 0, 0, 4'd3, 10'd13, 0, 0);
    add("br_not_taken", 0, 0, 0, 0, 1, 0, 4'd3, 10'd14, 0, 0);
    add("jmp_br_both",  0, 0, 0, 1, 1, 0, 4'd0, 10'd14, 1, 0);
    add("jmp_minus3",   0, 0, 0, 1, 0, 0, 4'd4, 10'd11, 1, 0);
    add("inc12",        0, 0, 0, 0, 0, 0, 4'd4, 10'd12, 0, 0);
    add("self_loop",    0, 0, 0, 1, 0, 0, 4'd0, 10'd12, 1, 0);
    add("jmp_to9",      0, 0, 0, 1, 0, 0, 4'd4, 10'd9,  1, 0);
    add("stall_halt1",  0, 1, 1, 0, 0, 0, 4'd0, 10'd9,  0, 0);
    add("stall_halt2",  0, 1, 1, 1, 0, 0, 4'd3, 10'd9,  0, 0);
    add("stall_halt3",  0, 1, 1, 0, 1, 1, 4'd3, 10'd9,  0, 0);
    add("halt_release", 0, 0, 1, 0, 0, 0, 4'd0, 10'd9,  0, 1);
    for (int i = 0; i < 4; i++)
      add($sformatf("done_hold9_%0d", i), 0, 0, 0, i[0], i[1], 1, 4'd3, 10'd9, 0, 1);
    add("restart",      1, 0, 0, 0, 0, 0, 4'd0, 10'd0,  0, 0);
    add("run1",         0, 0, 0, 0, 0, 0, 4'd0, 10'd1,  0, 0);
    add("run2",         0, 0, 0, 0, 0, 0, 4'd0, 10'd2,  0, 0);
    add("wrap_jmp",     0, 0, 0, 1, 0, 0, 4'd4, 10'd1023, 1, 0);
    add("wrap_inc",     0, 0, 0, 0, 0, 0, 4'd0, 10'd0,  0, 0);
    add("jmp16",        0, 0, 0, 1, 0, 0, 4'd6, 10'd16, 1, 0);
    add("br18",         0, 0, 0, 0, 1, 1, 4'd2, 10'd18, 1, 0);
    add("inc19",        0, 0, 0, 0, 0, 0, 4'd0, 10'd19, 0, 0);
    add("inc20",        0, 0, 0, 0, 0, 0, 4'd0, 10'd20, 0, 0);
    add("halt_jmp",     0, 0, 1, 1, 0, 0, 4'd3, 10'd20, 0, 1);
    for (int i = 0; i < 10; i++)
      add($sformatf("done_hold20_%0d", i), 0, 0, i[0], i[1], 0, 0, 4'd3, 10'd20, 0, 1);
    add("restart2",     1, 0, 0, 0, 0, 0, 4'd0, 10'd0,  0, 0);
    add("start_in_run", 1, 0, 0, 0, 0, 0, 4'd0, 10'd1,  0, 0);
    add("jmp50",        0, 0, 0, 1, 0, 0, 4'd7, 10'd50, 1, 0);

    // Reset state.
    step(1, 0, 0, 0, 0, 0, 0, 4'd0);
    step(1, 0, 0, 0, 0, 0, 0, 4'd0);
    chk3("reset", 10'd0, 0, 0);
`ifdef PC_CYCLE_CNT_EN
    chk("reset.cnt", cycle_count, 16'd0);
`endif

    foreach (vecs[k]) begin
      step(0, vecs[k].st, vecs[k].sl, vecs[k].h, vecs[k].j, vecs[k].b,
           vecs[k].f, vecs[k].idx);
      chk3(vecs[k].name, vecs[k].pc, vecs[k].tk, vecs[k].dn);
    end

    // Reset mid-RUN at pc=50 with a redirect pending: reset wins.
    step(1, 0, 0, 0, 1, 0, 0, 4'd3);
    chk3("mid_reset", 10'd0, 0, 0);
    // In IDLE without a start, the decoder strobes do nothing.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1, 0, 0, 4'd3);
      chk3($sformatf("idle_hold%0d", i), 10'd0, 0, 0);
    end
    step(0, 1, 0, 0, 0, 0, 0, 4'd0);
    chk3("start_after_reset", 10'd0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 4'd0);
    chk3("run_after_reset", 10'd1, 0, 0);

`ifdef PC_CYCLE_CNT_EN
    // Fresh run: start clears, 3 plain + 2 stalled + 1 halt RUN cycles -> 6.
    step(1, 0, 0, 0, 0, 0, 0, 4'd0);
    chk("cnt.reset", cycle_count, 16'd0);
    step(0, 1, 0, 0, 0, 0, 0, 4'd0);
    chk("cnt.start", cycle_count, 16'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 4'd0);
    for (int i = 0; i < 2; i++) step(0, 0, 1, 0, 0, 0, 0, 4'd0);
    chk("cnt.stalls", cycle_count, 16'd5);
    step(0, 0, 0, 1, 0, 0, 0, 4'd0);
    chk("cnt.done_rise.done", 16'(done), 16'd1);
    chk("cnt.done_rise", cycle_count, 16'd6);
    step(0, 0, 0, 0, 0, 0, 0, 4'd0);
    chk("cnt.done_hold", cycle_count, 16'd6);
    step(0, 1, 0, 0, 0, 0, 0, 4'd0);
    chk("cnt.restart", cycle_count, 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
